// File: rtl/ring_pkg.sv
// ring_pkg: shared definitions for the bidirectional ring router.
//   DATA_WIDTH       packet width in bits
//   HOP_MSB/HOP_LSB  hop-count field position inside a packet
//   VC_BIT/DIR_BIT   virtual-channel and direction bit positions
//   packet_t         one packet at the default width
//   dest_e           head-of-line destination decided by the hop field
package ring_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int HOP_MSB    = 55;
  localparam int HOP_LSB    = 48;
  localparam int VC_BIT     = 63;
  localparam int DIR_BIT    = 62;

  typedef logic [DATA_WIDTH-1:0] packet_t;

  typedef enum logic {
    DEST_RING = 1'b0,
    DEST_PE   = 1'b1
  } dest_e;

endpackage

// File: rtl/buffer_fifo.sv
// buffer_fifo: generic DEPTH x DATA_WIDTH circular FIFO.
//   clk, reset  clock, asynchronous active-high reset (control state only)
//   push        write wr_data at the tail (ignored when full)
//   pop         drop the head entry (ignored when empty)
//   wr_data     data written on push
//   head        entry at the read pointer (meaningful when !empty)
//   full/empty  occupancy flags from the registered count
module buffer_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        count;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/router_input_buffer.sv
// router_input_buffer: per-port input stage of the ring router.
// Buffers packets from a neighbour link and requests either the
// ring-forward or the PE-eject arbiter for the head packet.
//   clk, reset           clock, asynchronous active-high reset
//   in_si/in_ri/in_data  upstream valid/ready handshake and packet
//   ring_ready/pe_ready  downstream registers can take a packet
//   rq_ring/rq_pe        requests to the two prioritizers
//   gt_ring/gt_pe        grants back from the prioritizers
//   out_data             head packet, hop decremented when forwarded
module router_input_buffer #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 2,
  parameter int HOP_MSB    = 55,
  parameter int HOP_LSB    = 48
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_si,
  output logic                  in_ri,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  ring_ready,
  input  logic                  pe_ready,
  output logic                  rq_ring,
  output logic                  rq_pe,
  input  logic                  gt_ring,
  input  logic                  gt_pe,
  output logic [DATA_WIDTH-1:0] out_data
);

  import ring_pkg::*;

  localparam int HOP_W = HOP_MSB - HOP_LSB + 1;

  // Only the hop bits change; hop is known nonzero here so no wrap.
  function automatic logic [DATA_WIDTH-1:0] hop_dec(input logic [DATA_WIDTH-1:0] pkt);
    logic [DATA_WIDTH-1:0] r;
    r = pkt;
    r[HOP_MSB:HOP_LSB] = pkt[HOP_MSB:HOP_LSB] - HOP_W'(1);
    return r;
  endfunction

  logic [DATA_WIDTH-1:0] head;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  dest_e                 dest;

  buffer_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (in_data),
    .head    (head),
    .full    (full),
    .empty   (empty)
  );

  // Ready depends on registered occupancy only, so a same-cycle pop
  // never opens room for a push into a full buffer.
  assign in_ri = !reset && !full;
  assign push  = in_si && in_ri;

  assign dest    = (head[HOP_MSB:HOP_LSB] == '0) ? DEST_PE : DEST_RING;
  assign rq_pe   = !empty && (dest == DEST_PE)   && pe_ready;
  assign rq_ring = !empty && (dest == DEST_RING) && ring_ready;

  // A grant only counts against its own request.
  assign pop = (gt_ring && rq_ring) || (gt_pe && rq_pe);

  always_comb begin
    out_data = '0;
    if (!empty) begin
      out_data = (dest == DEST_PE) ? head : hop_dec(head);
    end
  end

endmodule

// File: tb/tb_router_input_buffer.sv
module tb_router_input_buffer;
  import ring_pkg::*;

  localparam int NV = 29;

  typedef struct packed {
    logic [63:0] data;
    logic        to_pe;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_si;
  logic        in_ri;
  packet_t     in_data;
  logic        ring_ready;
  logic        pe_ready;
  logic        rq_ring;
  logic        rq_pe;
  logic        gt_ring;
  logic        gt_pe;
  packet_t     out_data;

  packet_t     vec_d  [NV];
  packet_t     vec_e  [NV];
  logic        vec_pe [NV];
  exp_t        exp_q  [$];
  exp_t        e;

  int total = 0;
  int bad = 0;
  int cur = 0;
  int proto_err = 0;
  int pe_snap;
  int n;

  router_input_buffer #(
    .DATA_WIDTH (64),
    .DEPTH      (2),
    .HOP_MSB    (55),
    .HOP_LSB    (48)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_si      (in_si),
    .in_ri      (in_ri),
    .in_data    (in_data),
    .ring_ready (ring_ready),
    .pe_ready   (pe_ready),
    .rq_ring    (rq_ring),
    .rq_pe      (rq_pe),
    .gt_ring    (gt_ring),
    .gt_pe      (gt_pe),
    .out_data   (out_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor: every accepted grant must pop the oldest expected packet.
  always @(negedge clk) begin
    if (!reset) begin
      total++;
      if (rq_ring && rq_pe) begin
        bad++;
        $display("FAIL both_rq: got 11 want at most one");
      end
      if ((gt_ring && !rq_ring) || (gt_pe && !rq_pe)) begin
        proto_err++;
        $display("note: grant without request (protocol error) at %0t", $time);
      end
      if ((gt_ring && rq_ring) || (gt_pe && rq_pe)) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pop_unexpected: got %h want no pop", out_data);
        end else begin
          e = exp_q.pop_front();
          check("pop_data", out_data, e.data);
          check("pop_dest_pe", rq_pe, e.to_pe);
        end
      end
    end
  end

  // One clock: record an accepted push, then advance past the edge.
  task automatic step();
    #1;
    if (in_si && in_ri) begin
      exp_q.push_back(exp_t'{data: vec_e[cur], to_pe: vec_pe[cur]});
      cur++;
    end
    @(posedge clk);
    #1;
    if (cur < NV) in_data = vec_d[cur];
  endtask

  initial begin
    vec_d[0] = 64'h1203_0000_DEAD_BEEF; vec_e[0] = 64'h1202_0000_DEAD_BEEF; vec_pe[0] = 1'b0;
    vec_d[1] = 64'h4000_CAFE_F00D_1234; vec_e[1] = 64'h4000_CAFE_F00D_1234; vec_pe[1] = 1'b1;
    vec_d[2] = 64'h0101_1111_1111_1111; vec_e[2] = 64'h0100_1111_1111_1111; vec_pe[2] = 1'b0;
    vec_d[3] = 64'h0202_2222_2222_2222; vec_e[3] = 64'h0201_2222_2222_2222; vec_pe[3] = 1'b0;
    vec_d[4] = 64'h03FF_3333_3333_3333; vec_e[4] = 64'h03FE_3333_3333_3333; vec_pe[4] = 1'b0;
    vec_d[5] = 64'h0480_4444_4444_4444; vec_e[5] = 64'h047F_4444_4444_4444; vec_pe[5] = 1'b0;
    vec_d[6] = 64'hFF10_5555_5555_5555; vec_e[6] = 64'hFF0F_5555_5555_5555; vec_pe[6] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      vec_d[7+i]  = {8'(8'hA0 + i), 8'(i + 1), 48'h0000_0000_1000 + 48'(i)};
      vec_e[7+i]  = {8'(8'hA0 + i), 8'(i),     48'h0000_0000_1000 + 48'(i)};
      vec_pe[7+i] = 1'b0;
    end
    vec_d[27] = 64'h0005_0000_0000_0027; vec_e[27] = 64'h0004_0000_0000_0027; vec_pe[27] = 1'b0;
    vec_d[28] = 64'h8000_0000_0000_0028; vec_e[28] = 64'h8000_0000_0000_0028; vec_pe[28] = 1'b1;

    reset = 1'b1; in_si = 1'b0; in_data = '0; ring_ready = 1'b0; pe_ready = 1'b0;
    gt_ring = 1'b0; gt_pe = 1'b0;

    // Reset then idle
    #2;
    check("reset_in_ri", in_ri, 0);
    check("reset_rq_ring", rq_ring, 0);
    check("reset_rq_pe", rq_pe, 0);
    check("reset_count", dut.u_fifo.count, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    #1 check("release_in_ri", in_ri, 1);

    // Ring packet hop=3
    ring_ready = 1'b1; in_si = 1'b1; in_data = vec_d[cur];
    #1 check("push_cycle_no_rq", rq_ring, 0);
    step();
    in_si = 1'b0;
    #1;
    check("ring_rq_ring", rq_ring, 1);
    check("ring_rq_pe", rq_pe, 0);
    check("ring_out", out_data, vec_e[0]);
    check("ring_hop", out_data[55:48], 8'h02);
    gt_ring = 1'b1;
    step();
    gt_ring = 1'b0;
    #1;
    check("ring_empty_rq", rq_ring, 0);
    check("ring_empty_count", dut.u_fifo.count, 0);

    // PE packet hop=0, gated by pe_ready
    ring_ready = 1'b0; pe_ready = 1'b0; in_si = 1'b1; in_data = vec_d[cur];
    step();
    in_si = 1'b0;
    #1 check("pe_not_ready", rq_pe, 0);
    pe_ready = 1'b1;
    #1;
    check("pe_rq_pe", rq_pe, 1);
    check("pe_rq_ring", rq_ring, 0);
    check("pe_out_exact", out_data, 64'h4000_CAFE_F00D_1234);
    gt_pe = 1'b1;
    step();
    gt_pe = 1'b0; pe_ready = 1'b0;

    // Fill, hold in_si, single grants, pointer wrap over 5 packets
    ring_ready = 1'b0; in_si = 1'b1; in_data = vec_d[cur];
    step();
    step();
    #1 check("full_in_ri", in_ri, 0);
    step();
    check("full_hold_in_ri", in_ri, 0);
    check("full_count", dut.u_fifo.count, 2);
    ring_ready = 1'b1; gt_ring = 1'b1;
    step();
    gt_ring = 1'b0;
    #1 check("in_ri_after_pop", in_ri, 1);
    check("one_accept_pending", cur, 4);
    step();
    #1 check("refull_in_ri", in_ri, 0);
    gt_ring = 1'b1;
    step();
    step();
    step();
    in_si = 1'b0;
    step();
    gt_ring = 1'b0;
    #1;
    check("wrap_empty_rq", rq_ring, 0);
    check("wrap_accepted", cur, 7);

    // Streaming: grant every cycle, then alternate cycles
    ring_ready = 1'b1; gt_ring = 1'b1; in_si = 1'b1; in_data = vec_d[cur];
    for (int i = 0; i < 10; i++) step();
    check("stream_throughput", cur, 17);
    n = 0;
    while (cur < 27 && n < 40) begin
      gt_ring = ~gt_ring;
      step();
      n++;
    end
    in_si = 1'b0;
    check("stream_all_accepted", cur, 27);
    gt_ring = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      step();
      n++;
    end
    gt_ring = 1'b0;
    check("stream_drained", exp_q.size(), 0);
    #1 check("stream_idle_rq", rq_ring, 0);

    // Stray grant, then reset with two entries held
    ring_ready = 1'b0; pe_ready = 1'b1; in_si = 1'b1; in_data = vec_d[cur];
    step();
    in_si = 1'b0;
    #1 check("stray_rq_pe", rq_pe, 0);
    pe_snap = proto_err;
    gt_pe = 1'b1;
    step();
    gt_pe = 1'b0;
    check("stray_flagged", proto_err, pe_snap + 1);
    check("stray_no_pop", dut.u_fifo.count, 1);
    in_si = 1'b1;
    step();
    in_si = 1'b0;
    #1 check("two_held", dut.u_fifo.count, 2);
    ring_ready = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("midreset_count", dut.u_fifo.count, 0);
    check("midreset_in_ri", in_ri, 0);
    check("midreset_rq_ring", rq_ring, 0);
    check("midreset_rq_pe", rq_pe, 0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("post_reset_in_ri", in_ri, 1);
    check("post_reset_rq_ring", rq_ring, 0);
    check("post_reset_rq_pe", rq_pe, 0);

    repeat (2) @(posedge clk);
    #1 check("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/router_input_buffer.md
# router_input_buffer

Per-port input stage of the bidirectional ring router. It sits directly upstream of the two-requester `rotating_prioritizer` arbiters. It accepts packets from a neighbour link with a valid/ready handshake and holds them in a small FIFO. For the head packet it decodes the hop field and raises a request toward either the ring-forward arbiter or the PE-eject arbiter. It pops the head when the matching grant returns.

## Interface
- `DATA_WIDTH`, 64: packet width in bits.
- `DEPTH`, 2: FIFO entries; power of two, ≥2.
- `HOP_MSB`, 55: MSB of the hop-count field.
- `HOP_LSB`, 48: LSB of the hop-count field.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_si`  in  1  upstream offers a packet this cycle.
- `in_ri`  out  1  buffer can accept; `in_si && in_ri` = push.
- `in_data`  in  DATA_WIDTH  upstream packet.
- `ring_ready`  in  1  downstream ring output register can take a packet.
- `pe_ready`  in  1  PE eject register can take a packet.
- `rq_ring`  out  1  request to ring-forward prioritizer.
- `rq_pe`  out  1  request to PE-eject prioritizer.
- `gt_ring`  in  1  grant from ring-forward prioritizer.
- `gt_pe`  in  1  grant from PE-eject prioritizer.
- `out_data`  out  DATA_WIDTH  head packet, hop-adjusted, valid while either `rq_*` is high.

## Operation
- Storage: circular FIFO with `wr_ptr`, `rd_ptr` (log2 DEPTH bits, wrap modulo DEPTH) and `count` (log2 DEPTH + 1 bits).
- `in_ri = !reset && (count < DEPTH)`. It depends on registered state only. No push is allowed when full, even if a pop occurs in the same cycle.
- Head decode, with hop = `head[HOP_MSB:HOP_LSB]`:
  - If hop == 0: destination is PE.
  - Otherwise: destination is ring.
- `rq_pe = (count != 0) && hop == 0 && pe_ready`.
- `rq_ring = (count != 0) && hop != 0 && ring_ready`.
- At most one request is high per cycle.
- `out_data`:
  - Ring destination: head with the hop field decremented by 1. The decrement is DATA_WIDTH-agnostic and touches only the hop bits. No wrap is possible because hop != 0.
  - PE destination: head unchanged.
- Pop occurs when `(gt_ring && rq_ring) || (gt_pe && rq_pe)`.
- A grant without its own request is ignored; no pop. The bench flags it as a protocol error.
- Push and pop in the same cycle (non-empty, non-full): both pointers advance and `count` is unchanged.
- Push to an empty FIFO: the head becomes visible the next cycle.

## Timing
- Reset (asynchronous assert):
  - `count`, `wr_ptr`, `rd_ptr` are 0.
  - `in_ri` = 0 while `reset` is high.
  - `rq_ring` = `rq_pe` = 0.
  - `out_data` is don't-care (drive 0 when empty).
- Reset mid-operation discards all buffered packets immediately. After deassertion, `in_ri` = 1 on the first cycle.
- Latency:
  - Push accepted at edge N → `rq_*` can assert in cycle N+1.
  - Grant sampled at edge M → next head's request can assert in cycle M+1, with no bubble when count was ≥2.
- Throughput: one packet per cycle sustained when DEPTH ≥ 2 and grants arrive every cycle.
- `rq_*` and `out_data` are combinational from state plus `*_ready`. The prioritizer grant is combinational back, and the pop is registered.
- Full: `in_ri` goes low in the cycle after the DEPTH-th push. It rises the cycle after a pop.
- Empty: the requests drop in the cycle after the final pop.

## Structure
- Shared package `ring_pkg`:
  - `DATA_WIDTH`
  - `HOP_MSB`/`HOP_LSB`
  - VC and direction bit positions (63, 62)
  - typedef `packet_t`
- Sub-module `buffer_fifo`: generic DEPTH×DATA_WIDTH circular FIFO. It has push/pop/full/empty/head ports and contains the pointers and count.
- The top level holds the hop decode, request gating and hop decrement.

## Test plan
- Reset then idle:
  - During `reset`: `in_ri`=0, `rq_ring`=`rq_pe`=0.
  - Cycle after release: `in_ri`=1.
- Push a packet with hop=3, `ring_ready`=1 → the next cycle gives `rq_ring`=1, `rq_pe`=0, and `out_data` hop field = 2. Then `gt_ring`=1 → empty next cycle and `rq_ring`=0.
- Push a packet with hop=0, `pe_ready`=0 → `rq_pe`=0. Raise `pe_ready` → `rq_pe`=1 and `out_data` equals the input bit-for-bit.
- Fill to DEPTH=2 with no grants → `in_ri`=0. Hold `in_si`=1 and pulse one `gt_ring` → exactly one new packet is accepted, FIFO order is preserved, and pointers wrap correctly over 5 packets.
- Continuous `in_si` with `gt_ring` every cycle (the prioritizer alternating `rq_0`/`rq_1` is modelled by a grant on alternate cycles) → no packet lost or duplicated across 20 packets.
- `gt_pe`=1 while `rq_pe`=0 → no pop and an error is flagged. Assert `reset` with 2 entries held → `count` is 0 immediately, no stale request after release.
